// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one external memory/bus port between the IF stage
// (instruction fetch) and the MEM stage (load/store). MEM has fixed priority.
// Bus signals are registered and held until bus_ack; read data is returned to
// the owning stage with a one-cycle rdy pulse.
// Optional bus watchdog: define MEM_BUS_ARBITER_TIMEOUT_EN to compile in a
// TIMEOUT_W-bit counter that abandons a bus access that never acknowledges
// and reports it with a one-cycle bus_err pulse. Without the macro the
// arbiter waits indefinitely and bus_err is tied low.

module mem_bus_arbiter #(
    parameter int TIMEOUT_W = 8
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic [31:0] if_rd_data,
    output logic        if_rdy,
    output logic        if_busy,

    input  logic        mem_req,
    input  logic        mem_rw,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wr_data,
    input  logic [3:0]  mem_be,
    output logic [31:0] mem_rd_data,
    output logic        mem_rdy,
    output logic        mem_busy,

    output logic        bus_req,
    output logic        bus_rw,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wr_data,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rd_data,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_ACC  = 2'd1,
        MEM_ACC = 2'd2
    } state_t;

    state_t      state_reg, state_next;

    logic        bus_req_reg,     bus_req_next;
    logic        bus_rw_reg,      bus_rw_next;
    logic [31:0] bus_addr_reg,    bus_addr_next;
    logic [31:0] bus_wr_data_reg, bus_wr_data_next;
    logic [3:0]  bus_be_reg,      bus_be_next;

    logic [31:0] if_rd_data_reg,  if_rd_data_next;
    logic        if_rdy_reg,      if_rdy_next;
    logic [31:0] mem_rd_data_reg, mem_rd_data_next;
    logic        mem_rdy_reg,     mem_rdy_next;

    // Set when the in-flight fetch was flushed; its result must be discarded.
    logic        drop_reg,        drop_next;

    logic        bus_err_next;
    logic        timeout;

    // A stage whose rdy pulse is showing this cycle has just been served; its
    // request line may still be high for this one cycle, so it must not be
    // granted a second time.
    logic        mem_grant;
    logic        if_grant;

    assign mem_grant = mem_req & ~mem_rdy_reg;
    assign if_grant  = if_req  & ~if_rdy_reg & ~if_flush;

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
    // Expiry fires on the edge where the counter would reach its all-ones
    // value, so the bus request is held for exactly 2^TIMEOUT_W - 1 cycles.
    localparam logic [TIMEOUT_W-1:0] WDOG_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    logic [TIMEOUT_W-1:0] wdog_reg, wdog_next;
    logic                 bus_err_reg;

    assign timeout = (state_reg != IDLE) && !bus_ack && (wdog_reg == WDOG_LAST);

    // Watchdog: held at zero in IDLE so it starts cleared on every access.
    always_comb begin
        wdog_next = '0;
        if (state_reg != IDLE) begin
            wdog_next = wdog_reg + 1'b1;
        end
    end

    // Watchdog and error pulse registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdog_reg    <= '0;
            bus_err_reg <= 1'b0;
        end else begin
            wdog_reg    <= wdog_next;
            bus_err_reg <= bus_err_next;
        end
    end

    assign bus_err = bus_err_reg;
`else
    assign timeout = 1'b0;
    assign bus_err = 1'b0;
`endif

    // Next-state and next-register logic for the arbiter FSM.
    always_comb begin
        state_next       = state_reg;
        bus_req_next     = bus_req_reg;
        bus_rw_next      = bus_rw_reg;
        bus_addr_next    = bus_addr_reg;
        bus_wr_data_next = bus_wr_data_reg;
        bus_be_next      = bus_be_reg;
        if_rd_data_next  = if_rd_data_reg;
        if_rdy_next      = 1'b0;
        mem_rd_data_next = mem_rd_data_reg;
        mem_rdy_next     = 1'b0;
        drop_next        = drop_reg;
        bus_err_next     = 1'b0;

        case (state_reg)
            IDLE: begin
                drop_next = 1'b0;
                if (mem_grant) begin
                    bus_req_next     = 1'b1;
                    bus_rw_next      = mem_rw;
                    bus_addr_next    = mem_addr;
                    bus_wr_data_next = mem_wr_data;
                    bus_be_next      = mem_be;
                    state_next       = MEM_ACC;
                end else if (if_grant) begin
                    bus_req_next  = 1'b1;
                    bus_rw_next   = 1'b0;
                    bus_addr_next = if_addr;
                    bus_be_next   = 4'hf;
                    state_next    = IF_ACC;
                end
            end

            IF_ACC: begin
                if (bus_ack || timeout) begin
                    bus_req_next = 1'b0;
                    state_next   = IDLE;
                    drop_next    = 1'b0;
                    bus_err_next = timeout;
                    // A flush at any point of the access, including the
                    // completing edge, discards the fetched word.
                    if (!(drop_reg || if_flush)) begin
                        if_rdy_next     = 1'b1;
                        if_rd_data_next = bus_ack ? bus_rd_data : 32'h0;
                    end
                end else if (if_flush) begin
                    drop_next = 1'b1;
                end
            end

            MEM_ACC: begin
                if (bus_ack || timeout) begin
                    bus_req_next = 1'b0;
                    state_next   = IDLE;
                    mem_rdy_next = 1'b1;
                    bus_err_next = timeout;
                    if (timeout) begin
                        mem_rd_data_next = 32'h0;
                    end else if (!bus_rw_reg) begin
                        mem_rd_data_next = bus_rd_data;
                    end
                end
            end

            default: begin
                state_next   = IDLE;
                bus_req_next = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            bus_req_reg     <= 1'b0;
            bus_rw_reg      <= 1'b0;
            bus_addr_reg    <= 32'h0;
            bus_wr_data_reg <= 32'h0;
            bus_be_reg      <= 4'h0;
            if_rd_data_reg  <= 32'h0;
            if_rdy_reg      <= 1'b0;
            mem_rd_data_reg <= 32'h0;
            mem_rdy_reg     <= 1'b0;
            drop_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            bus_req_reg     <= bus_req_next;
            bus_rw_reg      <= bus_rw_next;
            bus_addr_reg    <= bus_addr_next;
            bus_wr_data_reg <= bus_wr_data_next;
            bus_be_reg      <= bus_be_next;
            if_rd_data_reg  <= if_rd_data_next;
            if_rdy_reg      <= if_rdy_next;
            mem_rd_data_reg <= mem_rd_data_next;
            mem_rdy_reg     <= mem_rdy_next;
            drop_reg        <= drop_next;
        end
    end

    assign bus_req     = bus_req_reg;
    assign bus_rw      = bus_rw_reg;
    assign bus_addr    = bus_addr_reg;
    assign bus_wr_data = bus_wr_data_reg;
    assign bus_be      = bus_be_reg;

    assign if_rd_data  = if_rd_data_reg;
    assign if_rdy      = if_rdy_reg;
    assign mem_rd_data = mem_rd_data_reg;
    assign mem_rdy     = mem_rdy_reg;

    // Stall a stage while its request is outstanding.
    assign if_busy  = if_req  & ~if_rdy_reg;
    assign mem_busy = mem_req & ~mem_rdy_reg;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed testbench for mem_bus_arbiter: table of single-transaction vectors
// plus hand-written sequences for reset, priority, flush and watchdog cases.
// Define MEM_BUS_ARBITER_TIMEOUT_EN to also exercise the watchdog.

module tb_mem_bus_arbiter;

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
    localparam int TW = 4;
`else
    localparam int TW = 8;
`endif

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic [31:0] if_rd_data;
    logic        if_rdy;
    logic        if_busy;
    logic        mem_req;
    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [3:0]  mem_be;
    logic [31:0] mem_rd_data;
    logic        mem_rdy;
    logic        mem_busy;
    logic        bus_req;
    logic        bus_rw;
    logic [31:0] bus_addr;
    logic [31:0] bus_wr_data;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rd_data;
    logic        bus_err;

    int checks = 0;
    int errors = 0;
    int err_seen = 0;
    int hi_cycles;

    typedef struct {
        logic        is_mem;
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          delay;    // bus cycles without ack before the ack cycle
        logic [31:0] rdata;
        logic [31:0] exp_rd;   // expected owner rd_data after completion
        string       name;
    } vec_t;

    vec_t vecs[6];
    vec_t v;

    mem_bus_arbiter #(.TIMEOUT_W(TW)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rd_data(if_rd_data), .if_rdy(if_rdy), .if_busy(if_busy),
        .mem_req(mem_req), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_be(mem_be),
        .mem_rd_data(mem_rd_data), .mem_rdy(mem_rdy), .mem_busy(mem_busy),
        .bus_req(bus_req), .bus_rw(bus_rw), .bus_addr(bus_addr),
        .bus_wr_data(bus_wr_data), .bus_be(bus_be),
        .bus_ack(bus_ack), .bus_rd_data(bus_rd_data), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus_err === 1'b1) err_seen++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one transaction at a negedge; return at the negedge after the
    // rdy cycle with all requests dropped.
    task automatic run_vec(input vec_t tv);
        if (tv.is_mem) begin
            mem_req = 1'b1; mem_rw = tv.rw; mem_addr = tv.addr;
            mem_wr_data = tv.wdata; mem_be = tv.be;
        end else begin
            if_req = 1'b1; if_addr = tv.addr;
        end
        @(negedge clk);
        for (int k = 0; k <= tv.delay; k++) begin
            chk({tv.name, " bus_req"}, bus_req, 1);
            chk({tv.name, " bus_addr"}, bus_addr, tv.addr);
            chk({tv.name, " bus_rw"}, bus_rw, tv.is_mem ? tv.rw : 1'b0);
            chk({tv.name, " bus_be"}, bus_be, tv.is_mem ? tv.be : 4'hf);
            if (tv.is_mem) begin
                chk({tv.name, " bus_wr_data"}, bus_wr_data, tv.wdata);
                chk({tv.name, " mem_busy"}, mem_busy, 1);
                chk({tv.name, " mem_rdy early"}, mem_rdy, 0);
            end else begin
                chk({tv.name, " if_busy"}, if_busy, 1);
                chk({tv.name, " if_rdy early"}, if_rdy, 0);
            end
            if (k == tv.delay) begin
                bus_ack = 1'b1;
                bus_rd_data = tv.rdata;
            end
            @(negedge clk);
        end
        bus_ack = 1'b0;
        bus_rd_data = 32'h0BAD_0BAD;
        chk({tv.name, " bus_req done"}, bus_req, 0);
        if (tv.is_mem) begin
            chk({tv.name, " mem_rdy"}, mem_rdy, 1);
            chk({tv.name, " mem_busy done"}, mem_busy, 0);
            chk({tv.name, " mem_rd_data"}, mem_rd_data, tv.exp_rd);
            mem_req = 1'b0;
        end else begin
            chk({tv.name, " if_rdy"}, if_rdy, 1);
            chk({tv.name, " if_busy done"}, if_busy, 0);
            chk({tv.name, " if_rd_data"}, if_rd_data, tv.exp_rd);
            if_req = 1'b0;
        end
        @(negedge clk);
        chk({tv.name, " rdy one cycle"}, {31'h0, (tv.is_mem ? mem_rdy : if_rdy)}, 0);
        $display("txn %s addr %h rd %h", tv.name, tv.addr,
                 tv.is_mem ? mem_rd_data : if_rd_data);
    endtask

    initial begin
        //             is_mem rw   addr          wdata         be    dly rdata         exp_rd
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,        4'h0, 2, 32'h0000_0013, 32'h0000_0013, "if_fetch_100"};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_3000, 32'h0,        4'h0, 0, 32'h1234_5678, 32'h1234_5678, "mem_read_3000"};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 4'h3, 1, 32'h5555_5555, 32'h1234_5678, "mem_write_2000"};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0,        4'h0, 0, 32'h0050_0093, 32'h0050_0093, "if_fetch_104"};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_3004, 32'h0,        4'h0, 3, 32'hCAFE_F00D, 32'hCAFE_F00D, "mem_read_3004"};
        vecs[5] = '{1'b1, 1'b1, 32'h0000_2004, 32'h0102_0304, 4'h8, 0, 32'h7777_7777, 32'hCAFE_F00D, "mem_write_2004"};

        reset = 1'b0;
        if_req = 1'b0; if_addr = 32'h0; if_flush = 1'b0;
        mem_req = 1'b0; mem_rw = 1'b0; mem_addr = 32'h0; mem_wr_data = 32'h0; mem_be = 4'h0;
        bus_ack = 1'b0; bus_rd_data = 32'h0;
        repeat (2) @(negedge clk);
        chk("reset bus_req", bus_req, 0);
        chk("reset bus_addr", bus_addr, 0);
        chk("reset if_rd_data", if_rd_data, 0);
        chk("reset mem_rd_data", mem_rd_data, 0);
        chk("reset rdy", {30'h0, if_rdy, mem_rdy}, 0);
        chk("reset bus_err", bus_err, 0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Reset in the middle of a MEM access clears everything at once.
        mem_req = 1'b1; mem_rw = 1'b0; mem_addr = 32'h0000_4000; mem_be = 4'hf;
        @(negedge clk);
        chk("rst_mid bus_req before", bus_req, 1);
        #2 reset = 1'b0; mem_req = 1'b0;
        #1;
        chk("rst_mid bus_req", bus_req, 0);
        chk("rst_mid bus_addr", bus_addr, 0);
        chk("rst_mid bus_be", bus_be, 0);
        chk("rst_mid bus_rw_wdata", {bus_rw, bus_wr_data[30:0]}, 0);
        chk("rst_mid if_rd_data", if_rd_data, 0);
        chk("rst_mid mem_rd_data", mem_rd_data, 0);
        @(negedge clk);
        reset = 1'b1;
        bus_ack = 1'b1; bus_rd_data = 32'hFFFF_FFFF;
        @(negedge clk);
        bus_ack = 1'b0;
        chk("stray_ack rdy", {30'h0, if_rdy, mem_rdy}, 0);
        chk("stray_ack bus_req", bus_req, 0);
        chk("stray_ack mem_rd_data", mem_rd_data, 0);
        $display("txn reset_mid_mem done");
        v = '{1'b0, 1'b0, 32'h0000_0500, 32'h0, 4'h0, 1, 32'h0000_0A0A, 32'h0000_0A0A, "if_after_reset"};
        run_vec(v);

        // Simultaneous requests: MEM write first, one IDLE cycle, then IF.
        if_req = 1'b1; if_addr = 32'h0000_0200;
        mem_req = 1'b1; mem_rw = 1'b1; mem_addr = 32'h0000_2000;
        mem_wr_data = 32'hDEAD_BEEF; mem_be = 4'b0011;
        @(negedge clk);
        chk("prio bus_addr", bus_addr, 32'h0000_2000);
        chk("prio bus_rw", bus_rw, 1);
        chk("prio bus_be", bus_be, 4'b0011);
        chk("prio bus_wr_data", bus_wr_data, 32'hDEAD_BEEF);
        chk("prio if_busy", if_busy, 1);
        bus_ack = 1'b1; bus_rd_data = 32'h0;
        @(negedge clk);
        bus_ack = 1'b0;
        chk("prio mem_rdy", mem_rdy, 1);
        chk("prio idle bus_req", bus_req, 0);
        chk("prio if_rdy idle", if_rdy, 0);
        mem_req = 1'b0;
        @(negedge clk);
        chk("prio if bus_req", bus_req, 1);
        chk("prio if bus_addr", bus_addr, 32'h0000_0200);
        chk("prio if bus_rw_be", {bus_rw, bus_be}, 5'h0f);
        bus_ack = 1'b1; bus_rd_data = 32'h0000_0067;
        @(negedge clk);
        bus_ack = 1'b0;
        chk("prio if_rdy", if_rdy, 1);
        chk("prio if_rd_data", if_rd_data, 32'h0000_0067);
        if_req = 1'b0;
        @(negedge clk);
        $display("txn priority_mem_then_if done");

        // Flush during IF_ACC: the fetch completes on the bus but is dropped.
        if_req = 1'b1; if_addr = 32'h0000_0300;
        @(negedge clk);
        chk("flush bus_req", bus_req, 1);
        if_flush = 1'b1; if_req = 1'b0;
        @(negedge clk);
        if_flush = 1'b0;
        chk("flush bus held", bus_addr, 32'h0000_0300);
        bus_ack = 1'b1; bus_rd_data = 32'hAAAA_AAAA;
        @(negedge clk);
        bus_ack = 1'b0;
        chk("flush if_rdy", if_rdy, 0);
        chk("flush if_rd_data", if_rd_data, 32'h0000_0067);
        chk("flush bus_req done", bus_req, 0);
        @(negedge clk);
        chk("flush if_rdy late", if_rdy, 0);
        $display("txn flush_in_if_acc done");
        v = '{1'b0, 1'b0, 32'h0000_0304, 32'h0, 4'h0, 0, 32'h0000_0EF0, 32'h0000_0EF0, "if_after_flush"};
        run_vec(v);

        // Flush in IDLE only blocks the grant for that cycle.
        if_req = 1'b1; if_addr = 32'h0000_0400; if_flush = 1'b1;
        @(negedge clk);
        chk("idle_flush no grant", bus_req, 0);
        if_flush = 1'b0;
        @(negedge clk);
        chk("idle_flush grant", bus_req, 1);
        chk("idle_flush addr", bus_addr, 32'h0000_0400);
        bus_ack = 1'b1; bus_rd_data = 32'h0000_0077;
        @(negedge clk);
        bus_ack = 1'b0;
        chk("idle_flush if_rdy", if_rdy, 1);
        chk("idle_flush if_rd_data", if_rd_data, 32'h0000_0077);
        if_req = 1'b0;
        @(negedge clk);
        $display("txn flush_in_idle done");

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
        v = '{1'b1, 1'b0, 32'h0000_6000, 32'h0, 4'hf, 0, 32'h600D_600D, 32'h600D_600D, "mem_read_6000"};
        run_vec(v);
        mem_req = 1'b1; mem_rw = 1'b0; mem_addr = 32'h0000_5000; mem_be = 4'hf;
        @(negedge clk);
        hi_cycles = 0;
        while (bus_req === 1'b1 && hi_cycles < 40) begin
            hi_cycles++;
            @(negedge clk);
        end
        chk("timeout bus_req cycles", hi_cycles, 15);
        chk("timeout mem_rdy", mem_rdy, 1);
        chk("timeout bus_err", bus_err, 1);
        chk("timeout mem_rd_data", mem_rd_data, 0);
        mem_req = 1'b0;
        @(negedge clk);
        chk("timeout bus_err one cycle", bus_err, 0);
        $display("txn mem_timeout done");
        chk("bus_err pulse count", err_seen, 1);
`else
        chk("bus_err never set", err_seen, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single external memory/bus port between the IF stage (instruction fetch) and the MEM stage (load/store).
- Serializes requests, holds bus signals stable until the bus acknowledges, returns read data to the owning stage, and raises per-stage busy signals that the main controller turns into pipeline stalls.
- MEM has fixed priority over IF, because the MEM-stage instruction is older.
- Sits between the core pipeline and the bus interface.

Parameters:
- TIMEOUT_W, 8, width of the bus-watchdog counter. Used only when the optional feature is compiled in.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  IF fetch request, held until if_rdy.
- if_addr  in  32  fetch address.
- if_flush  in  1  IF flush from main controller.
- if_rd_data  out  32  fetched instruction word.
- if_rdy  out  1  one-cycle pulse: if_rd_data valid.
- if_busy  out  1  IF must stall.
- mem_req  in  1  MEM access request, held until mem_rdy.
- mem_rw  in  1  1 = write, 0 = read.
- mem_addr  in  32  data address.
- mem_wr_data  in  32  store data.
- mem_be  in  4  byte enables for writes.
- mem_rd_data  out  32  load data.
- mem_rdy  out  1  one-cycle pulse: access complete.
- mem_busy  out  1  MEM must stall.
- bus_req  out  1  bus request.
- bus_rw  out  1  bus direction.
- bus_addr  out  32  bus address.
- bus_wr_data  out  32  bus write data.
- bus_be  out  4  bus byte enables.
- bus_ack  in  1  bus completion, sampled on the rising edge.
- bus_rd_data  in  32  bus read data, valid with bus_ack.
- bus_err  out  1  one-cycle timeout-error pulse.

Behaviour:
- Reset (reset = 0, asynchronous):
  - State goes to IDLE; drop flag and watchdog clear.
  - All outputs are 0, including the registered bus_* outputs, both rd_data outputs, both rdy pulses and bus_err.
- State machine, registered. States: IDLE, IF_ACC, MEM_ACC.
- IDLE:
  - If mem_req = 1: latch mem_rw/addr/wr_data/be onto the bus_* registers, set bus_req = 1, go to MEM_ACC.
  - Else if if_req = 1 and if_flush = 0: latch if_addr, force bus_rw = 0 and bus_be = 4'hf, set bus_req = 1, go to IF_ACC.
  - bus_ack arriving in IDLE is ignored.
- IF_ACC and MEM_ACC:
  - bus_* outputs stay constant until an edge with bus_ack = 1.
  - On that edge: capture bus_rd_data into the owner's rd_data register, pulse the owner's rdy in the next cycle, clear bus_req, return to IDLE.
- Latency: request seen in cycle n → bus_req in n+1 → earliest ack in n+1 → rdy in n+2.
- After every completion the arbiter spends exactly one cycle in IDLE before it can issue again.
- Simultaneous if_req and mem_req in IDLE: MEM is granted, IF waits. IF is granted in the first IDLE cycle in which mem_req = 0.
- Busy signals (combinational):
  - if_busy = if_req & ~if_rdy.
  - mem_busy = mem_req & ~mem_rdy.
- IF flush:
  - if_flush = 1 during IF_ACC, or in the cycle the IF ack completes, sets a drop flag.
  - The bus transaction is never aborted.
  - On completion, if_rdy is suppressed, if_rd_data is unchanged, and the drop flag clears.
  - if_flush in IDLE only blocks the IF grant for that cycle.
- MEM requests are never cancelled. Once granted, a MEM access always completes.
- mem_rd_data is updated only for reads. Writes pulse mem_rdy and leave mem_rd_data unchanged.
- rd_data registers hold their value between accesses.

Optional Feature:
- Macro: MEM_BUS_ARBITER_TIMEOUT_EN.
- Defined:
  - A TIMEOUT_W-bit counter clears on entry to IF_ACC/MEM_ACC and increments each cycle without bus_ack.
  - When it reaches 2^TIMEOUT_W − 1 with no ack: clear bus_req, return to IDLE, load 0 into the owner's rd_data, pulse the owner's rdy and bus_err together for one cycle.
  - An IF timeout while the drop flag is set suppresses if_rdy but still pulses bus_err.
- Undefined: no counter; the arbiter waits indefinitely for bus_ack; bus_err is tied to 0.

Test Plan:
- Reset mid-MEM_ACC with bus_req = 1 → all outputs 0 immediately; a later stray bus_ack is ignored; the next if_req is granted normally.
- if_req, if_addr = 32'h0000_0100; bus_ack two cycles after bus_req with bus_rd_data = 32'h0000_0013 → bus_addr 32'h100, bus_rw 0, bus_be 4'hf; if_rd_data = 32'h13 with a one-cycle if_rdy; if_busy high until then.
- if_req and mem_req (write, addr 32'h2000, data 32'hDEAD_BEEF, be 4'b0011) in the same cycle → bus carries the MEM write first; mem_rdy pulses; exactly one IDLE cycle; then the IF fetch issues.
- if_flush pulsed during IF_ACC, ack with data 32'hAAAA_AAAA → no if_rdy; if_rd_data keeps its old value; the next fetch completes normally.
- MEM read, addr 32'h3000, ack in the first bus cycle with data 32'h1234_5678 → mem_rdy exactly two cycles after mem_req; mem_rd_data = 32'h1234_5678.
- With MEM_BUS_ARBITER_TIMEOUT_EN and TIMEOUT_W = 4, no ack → after 15 cycles bus_req drops; mem_rdy and bus_err pulse together; mem_rd_data = 0.
